// File: rtl/wb_select_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wb_pkg
// Purpose  : Shared types and constants for the write-back source selector.
//            Load-size encoding used by the load extender, and the canonical
//            source index assignment of the multicycle datapath.
// Revision : 1.0  initial release
// ============================================================================
package wb_pkg;

    // Load access size; 2'b11 is reserved and behaves like a full word.
    typedef enum logic [1:0] {
        LS_WORD = 2'b00,
        LS_HALF = 2'b01,
        LS_BYTE = 2'b10
    } ls_size_t;

    // Write-back source indices
    localparam int SRC_ALUOUT   = 0;
    localparam int SRC_LS       = 1;
    localparam int SRC_HI       = 2;
    localparam int SRC_LO       = 3;
    localparam int SRC_SE1      = 4;
    localparam int SRC_SE16     = 5;
    localparam int SRC_SHL      = 6;
    localparam int SRC_REGSHIFT = 7;
    localparam int SRC_CONST227 = 8;

endpackage : wb_pkg
`default_nettype wire

// File: rtl/wb_select_if.sv
`default_nettype none
// ============================================================================
// Module   : wb_select_if
// Purpose  : Bundle of request-side and register-file-side signals of the
//            write-back selector.
//   Request  : in_valid, in_ready, sel, src, dest, ls_size, ls_signed, flush
//   Result   : wb_valid, wb_ready, Write_data, wb_dest, wb_we, sel_err
//   Modports : master (datapath / testbench side), slave (selector side)
// Revision : 1.0  initial release
// ============================================================================
interface wb_select_if #(
    parameter int DATA_W = 32,
    parameter int NSRC   = 16,
    parameter int ADDR_W = 5
);
    localparam int SEL_W = $clog2(NSRC);

    logic                   in_valid;
    logic                   in_ready;
    logic [SEL_W-1:0]       sel;
    logic [NSRC*DATA_W-1:0] src;
    logic [ADDR_W-1:0]      dest;
    logic [1:0]             ls_size;
    logic                   ls_signed;
    logic                   flush;
    logic                   wb_valid;
    logic                   wb_ready;
    logic [DATA_W-1:0]      Write_data;
    logic [ADDR_W-1:0]      wb_dest;
    logic                   wb_we;
    logic                   sel_err;

    modport master (
        output in_valid, sel, src, dest, ls_size, ls_signed, flush, wb_ready,
        input  in_ready, wb_valid, Write_data, wb_dest, wb_we, sel_err
    );

    modport slave (
        input  in_valid, sel, src, dest, ls_size, ls_signed, flush, wb_ready,
        output in_ready, wb_valid, Write_data, wb_dest, wb_we, sel_err
    );

endinterface : wb_select_if
`default_nettype wire

// File: rtl/wb_select_load_ext.sv
`default_nettype none
// ============================================================================
// Module   : load_ext
// Purpose  : Combinational size / sign extension of raw load data.
//   din       : raw load word
//   ls_size   : 00 word, 01 half [15:0], 10 byte [7:0], 11 treated as word
//   ls_signed : 1 replicate field MSB into upper bits, 0 zero-fill
//   dout      : extended word
// Revision : 1.0  initial release
// ============================================================================
module load_ext
    import wb_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] din,
    input  logic [1:0]        ls_size,
    input  logic              ls_signed,
    output logic [DATA_W-1:0] dout
);

    always_comb begin
        dout = din;
        case (ls_size_t'(ls_size))
            LS_HALF: dout = {{(DATA_W-16){ls_signed & din[15]}}, din[15:0]};
            LS_BYTE: dout = {{(DATA_W-8){ls_signed & din[7]}}, din[7:0]};
            default: dout = din;
        endcase
    end

endmodule : load_ext
`default_nettype wire

// File: rtl/wb_select.sv
`default_nettype none
// ============================================================================
// Module   : wb_select
// Purpose  : Write-back source selector. Picks one of NSRC sources, optionally
//            extends load data on source LS_IDX, and holds the result with its
//            destination in a one-entry valid/ready stage toward the register
//            file. Generates write-enable (suppressed for register 0) and a
//            sticky illegal-select flag.
//   clk, reset : clock, synchronous active-high reset
//   bus        : wb_select_if.slave (request in, result out)
// Build option : WB_LOAD_EXT_EN -- when defined, source LS_IDX is size/sign
//                extended per ls_size/ls_signed; otherwise passed unmodified.
// Revision : 1.0  initial release
// ============================================================================
module wb_select
    import wb_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NSRC   = 16,
    parameter int LS_IDX = SRC_LS,
    parameter int ADDR_W = 5
) (
    input  logic        clk,
    input  logic        reset,
    wb_select_if.slave  bus
);

    localparam int SEL_W = $clog2(NSRC);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic [ADDR_W-1:0] r_dest;
    logic              r_sel_err;

    logic              w_in_ready;
    logic              w_accept;
    logic              w_sel_ok;
    logic [DATA_W-1:0] w_raw;
    logic [DATA_W-1:0] w_ext;
    logic [DATA_W-1:0] w_capture;

    // One-entry stage: free when empty or being drained this cycle.
    assign w_in_ready = !r_valid || bus.wb_ready;
    assign w_accept   = bus.in_valid && w_in_ready && !bus.flush;
    assign w_sel_ok   = int'(bus.sel) < NSRC;

    // Out-of-range selects fall through with zero data.
    always_comb begin
        w_raw = '0;
        for (int k = 0; k < NSRC; k++) begin
            if (bus.sel == SEL_W'(k)) begin
                w_raw = bus.src[k*DATA_W +: DATA_W];
            end
        end
    end

`ifdef WB_LOAD_EXT_EN
    logic [DATA_W-1:0] w_ld_ext;

    load_ext #(
        .DATA_W    (DATA_W)
    ) u_load_ext (
        .din       (w_raw),
        .ls_size   (bus.ls_size),
        .ls_signed (bus.ls_signed),
        .dout      (w_ld_ext)
    );

    assign w_ext = (bus.sel == SEL_W'(LS_IDX)) ? w_ld_ext : w_raw;
`else
    logic w_unused_ls;

    assign w_ext       = w_raw;
    assign w_unused_ls = ^{bus.ls_size, bus.ls_signed};
`endif

    assign w_capture = w_sel_ok ? w_ext : '0;

    // Flush outranks both accept and drain; data/dest only move on accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid   <= 1'b0;
            r_data    <= '0;
            r_dest    <= '0;
            r_sel_err <= 1'b0;
        end else if (bus.flush) begin
            r_valid   <= 1'b0;
        end else if (w_accept) begin
            r_valid   <= 1'b1;
            r_data    <= w_capture;
            r_dest    <= bus.dest;
            if (!w_sel_ok) begin
                r_sel_err <= 1'b1;
            end
        end else if (r_valid && bus.wb_ready) begin
            r_valid   <= 1'b0;
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.wb_valid   = r_valid;
    assign bus.Write_data = r_data;
    assign bus.wb_dest    = r_dest;
    assign bus.wb_we      = r_valid && (r_dest != '0);
    assign bus.sel_err    = r_sel_err;

endmodule : wb_select
`default_nettype wire
